// File: rtl/arm_mmio_timer.sv
// rtl/arm_mmio_timer.sv - data-side memory: word RAM, timer/LED MMIO window, unmapped hole
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous active-high reset
//   we     write enable from the core (MemWrite)
//   a      byte address from the core (DataAdr), bits [1:0] ignored
//   wd     write data from the core (WriteData)
//   rd     combinational read data back to the core (ReadData)
//   led    LED register contents
//   irq    timer interrupt, STATUS.MATCH gated by CTRL.IRQEN
//
// Register window at MMIO_BASE (byte offsets):
//   0x00 CTRL      [0] EN, [1] AUTORELOAD, [2] IRQEN
//   0x04 PRESCALE  [PRESCALE_W-1:0]
//   0x08 COUNT     32-bit
//   0x0C COMPARE   32-bit
//   0x10 STATUS    [0] MATCH, sticky, write-1-to-clear
//   0x14 LED       [7:0]
//   0x18, 0x1C     reserved, read 0

module arm_mmio_timer #(
  parameter int          RAM_WORDS  = 64,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_0200,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [7:0]  led,
  output logic        irq
);

  localparam int          RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] RAM_LIMIT = 32'(4 * RAM_WORDS);
  localparam logic [31:0] MMIO_END  = MMIO_BASE + 32'h20;
  localparam logic [PRESCALE_W-1:0] PCNT_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_COMPARE  = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;
  localparam logic [2:0] REG_LED      = 3'd5;

  // State
  logic [31:0]           ram_q [RAM_WORDS];
  logic [2:0]            ctrl_q,     ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pcnt_q,     pcnt_d;
  logic [31:0]           count_q,    count_d;
  logic [31:0]           compare_q,  compare_d;
  logic                  match_q,    match_d;
  logic [7:0]            led_q,      led_d;

  // Address decode. The mask drops the byte-lane bits so the region
  // compares behave as if made on a[31:2] alone.
  logic [31:0]       a_w;
  logic              ram_sel;
  logic              mmio_sel;
  logic [2:0]        reg_sel;
  logic [RAM_AW-1:0] ram_idx;

  assign a_w      = a & ~32'h3;
  assign ram_sel  = (a_w < RAM_LIMIT);
  // RAM takes priority should a large RAM ever overlap the window.
  assign mmio_sel = !ram_sel && (a_w >= MMIO_BASE) && (a_w < MMIO_END);
  assign reg_sel  = a_w[4:2];
  assign ram_idx  = a_w[RAM_AW+1:2];

  // Register write strobes
  logic wr_mmio;
  logic wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status, wr_led;

  assign wr_mmio     = we && mmio_sel;
  assign wr_ctrl     = wr_mmio && (reg_sel == REG_CTRL);
  assign wr_prescale = wr_mmio && (reg_sel == REG_PRESCALE);
  assign wr_count    = wr_mmio && (reg_sel == REG_COUNT);
  assign wr_compare  = wr_mmio && (reg_sel == REG_COMPARE);
  assign wr_status   = wr_mmio && (reg_sel == REG_STATUS);
  assign wr_led      = wr_mmio && (reg_sel == REG_LED);

  // Timer events use the registered CTRL, so a CTRL write only changes
  // behaviour from the following cycle.
  logic tick;
  logic hit;

  assign tick = ctrl_q[0] && (pcnt_q == prescale_q);
  assign hit  = tick && (count_q == compare_q);

  // Next-state logic
  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    count_d    = count_q;
    compare_d  = compare_q;
    match_d    = match_q;
    led_d      = led_q;

    // Prescaler runs only while enabled; a tick folds it back to zero.
    if (ctrl_q[0]) begin
      pcnt_d = tick ? '0 : (pcnt_q + PCNT_ONE);
    end

    if (tick) begin
      count_d = (hit && ctrl_q[1]) ? 32'd0 : (count_q + 32'd1);
    end

    if (wr_ctrl) begin
      ctrl_d = wd[2:0];
    end

    // Changing the prescale period restarts the prescaler.
    if (wr_prescale) begin
      prescale_d = wd[PRESCALE_W-1:0];
      pcnt_d     = '0;
    end

    // Software write to COUNT overrides the tick update.
    if (wr_count) begin
      count_d = wd;
    end

    if (wr_compare) begin
      compare_d = wd;
    end

    // W1C first, then a same-cycle match sets it again.
    if (wr_status && wd[0]) begin
      match_d = 1'b0;
    end
    if (hit) begin
      match_d = 1'b1;
    end

    if (wr_led) begin
      led_d = wd[7:0];
    end
  end

  // Peripheral registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      count_q    <= '0;
      compare_q  <= 32'hFFFF_FFFF;
      match_q    <= 1'b0;
      led_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
      led_q      <= led_d;
    end
  end

  // Data RAM has no reset; writes are blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset && we && ram_sel) begin
      ram_q[ram_idx] <= wd;
    end
  end

  // Combinational read path: the core has no stall.
  always_comb begin
    rd = '0;
    if (ram_sel) begin
      rd = ram_q[ram_idx];
    end else if (mmio_sel) begin
      case (reg_sel)
        REG_CTRL:     rd = {29'd0, ctrl_q};
        REG_PRESCALE: rd = 32'(prescale_q);
        REG_COUNT:    rd = count_q;
        REG_COMPARE:  rd = compare_q;
        REG_STATUS:   rd = {31'd0, match_q};
        REG_LED:      rd = {24'd0, led_q};
        default:      rd = '0;
      endcase
    end
  end

  assign led = led_q;
  assign irq = match_q && ctrl_q[2];

endmodule
